// File: rtl/lfsr_table_keygen.sv
// rtl/lfsr_table_keygen.sv - LFSR-filled lookup table with registered entry and round-key read ports
// Optional build macro LFSR_SEED_FIX_EN: a zero seed is replaced by SEED so the LFSR cannot lock up.
module lfsr_table_keygen #(
   parameter int             W     = 8,
   parameter int             DEPTH = 256,
   parameter logic [W-1:0]   TAPS  = 8'h1D,
   parameter logic [W-1:0]   SEED  = 8'h1D,
   parameter int             KEY_W = 128,
   localparam int            EPK      = KEY_W / W,
   localparam int            NUM_KEYS = DEPTH / EPK,
   localparam int            AW       = $clog2(DEPTH),
   localparam int            KW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic             clk,
   input  logic             rst_an,
   input  logic             start,
   input  logic [W-1:0]     seed_i,
   output logic             busy,
   output logic             valid,
   output logic             done_p,
   output logic             seed_err,
   input  logic [AW-1:0]    rd_addr,
   output logic [W-1:0]     rd_data,
   input  logic [KW-1:0]    key_idx,
   output logic [KEY_W-1:0] key_o
);

`ifdef LFSR_SEED_FIX_EN
   localparam bit FIX_EN = 1'b1;
`else
   localparam bit FIX_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

   state_t           st, st_nxt;
   logic [W-1:0]     lfsr;
   logic [W-1:0]     lfsr_nxt;
   logic [W-1:0]     load_seed;
   logic [AW-1:0]    cnt;
   logic [W-1:0]     mem [DEPTH];
   logic             accept;
   logic             last;
   logic             key_in_range;
   logic [KEY_W-1:0] key_word;

   assign accept    = start && (st != GEN);
   assign last      = (st == GEN) && (cnt == AW'(DEPTH - 1));
   assign busy      = (st == GEN);
   assign lfsr_nxt  = {^(lfsr & TAPS), lfsr[W-1:1]};
   assign load_seed = (FIX_EN && (seed_i == '0)) ? SEED : seed_i;

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) st <= IDLE;
      else         st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE, DONE: if (start) st_nxt = GEN;
         GEN:        if (last)  st_nxt = DONE;
         default:    st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         lfsr     <= '0;
         cnt      <= '0;
         valid    <= 1'b0;
         done_p   <= 1'b0;
         seed_err <= 1'b0;
      end else begin
         done_p   <= last;
         seed_err <= accept && (seed_i == '0);
         if (accept) begin
            lfsr  <= load_seed;
            cnt   <= '0;
            valid <= 1'b0;
         end else if (st == GEN) begin
            lfsr <= lfsr_nxt;
            cnt  <= cnt + AW'(1);
            if (last) valid <= 1'b1;
         end
      end
   end

   // Table storage carries no reset: its contents are masked by valid.
   always_ff @(posedge clk) begin
      if (st == GEN) mem[cnt] <= lfsr;
   end

   // First entry of a key lands in its most significant bits.
   always_comb begin
      key_word = '0;
      for (int e = 0; e < EPK; e++)
         key_word[KEY_W-1-e*W -: W] = mem[AW'(int'(key_idx) * EPK + e)];
   end

   assign key_in_range = (int'(key_idx) < NUM_KEYS);

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         rd_data <= '0;
         key_o   <= '0;
      end else begin
         rd_data <= valid ? mem[rd_addr] : '0;
         key_o   <= (valid && key_in_range) ? key_word : '0;
      end
   end

endmodule

// File: tb/tb_lfsr_table_keygen.sv
// tb/tb_lfsr_table_keygen.sv - scoreboard bench for lfsr_table_keygen (default and small configurations)
module tb_lfsr_table_keygen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_an;
   logic         start0, busy0, valid0, done0, serr0;
   logic [7:0]   seed0, rd_addr0, rd_data0;
   logic [3:0]   kidx0;
   logic [127:0] key0;
   logic         start1, busy1, valid1, done1, serr1;
   logic [3:0]   seed1, rd_data1, kidx1;
   logic [5:0]   rd_addr1;
   logic [15:0]  key1;

   lfsr_table_keygen dut0 (
      .clk(clk), .rst_an(rst_an), .start(start0), .seed_i(seed0),
      .busy(busy0), .valid(valid0), .done_p(done0), .seed_err(serr0),
      .rd_addr(rd_addr0), .rd_data(rd_data0), .key_idx(kidx0), .key_o(key0)
   );

   lfsr_table_keygen #(.W(4), .DEPTH(64), .TAPS(4'h9), .SEED(4'h1), .KEY_W(16)) dut1 (
      .clk(clk), .rst_an(rst_an), .start(start1), .seed_i(seed1),
      .busy(busy1), .valid(valid1), .done_p(done1), .seed_err(serr1),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .key_idx(kidx1), .key_o(key1)
   );

   typedef struct {
      logic [127:0] key;
      logic [7:0]   rd;
      bit           sel;
      string        tag;
   } exp_t;

   exp_t       sbq[$];
   logic       req   = 1'b0;
   logic       req_d = 1'b0;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] model [256];

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) req_d <= req;

   always @(negedge clk) begin
      exp_t e;
      if (req_d) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got read with empty queue expected queued item");
         end else begin
            e = sbq.pop_front();
            if (!e.sel) begin
               check({e.tag, "_rd"}, rd_data0, e.rd);
               check({e.tag, "_key"}, key0, e.key);
            end else begin
               check({e.tag, "_rd"}, rd_data1, e.rd);
               check({e.tag, "_key"}, key1, e.key);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic void build_model(logic [7:0] s);
      logic [7:0] x;
      x = s;
      for (int i = 0; i < 256; i++) begin
         model[i] = x;
         x = {^(x & 8'h1D), x[7:1]};
      end
   endfunction

   function automatic logic [127:0] mkey(int k);
      logic [127:0] r;
      r = '0;
      for (int e = 0; e < 16; e++) r = {r[119:0], model[k*16+e]};
      return r;
   endfunction

   // Caller is at a falling edge; the result is checked by the monitor one edge later.
   task automatic rd(input bit sel, input logic [7:0] a, input logic [3:0] k,
                     input logic [7:0] er, input logic [127:0] ek, input string tag);
      exp_t e;
      if (!sel) begin rd_addr0 = a; kidx0 = k; end
      else begin rd_addr1 = a[5:0]; kidx1 = k; end
      e.key = ek; e.rd = er; e.sel = sel; e.tag = tag;
      sbq.push_back(e);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic check_table(input string tag);
      for (int a = 0; a < 256; a++)
         rd(1'b0, 8'(a), 4'(a), model[a], mkey(a % 16), tag);
   endtask

   task automatic run_gen(input logic [7:0] s, input int restart_at, input int reset_at,
                          output int bc, output int dc, output int ec);
      seed0 = s;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      bc = 0; dc = 0; ec = 0;
      check("valid_low_after_start", valid0, 1'b0);
      for (int c = 0; c < 400; c++) begin
         if (busy0) bc++;
         if (serr0) ec++;
         if (done0) begin dc++; break; end
         start0 = 1'b0;
         req = 1'b0;
         if (bc == restart_at) begin start0 = 1'b1; seed0 = 8'h55; end
         if (bc == 10) begin
            exp_t e;
            rd_addr0 = 8'd0; kidx0 = 4'd0;
            e.key = '0; e.rd = '0; e.sel = 1'b0; e.tag = "gen_rd";
            sbq.push_back(e);
            req = 1'b1;
         end
         if (bc == reset_at) begin
            rst_an = 1'b0;
            #1;
            check("rst_mid_busy", busy0, 1'b0);
            check("rst_mid_valid", valid0, 1'b0);
            check("rst_mid_rd", rd_data0, 8'h00);
            check("rst_mid_key", key0, 128'h0);
            @(negedge clk);
            rst_an = 1'b1;
            return;
         end
         @(negedge clk);
      end
      start0 = 1'b0;
      req = 1'b0;
   endtask

   task automatic check_run(input string tag, input int bc, input int dc, input int ec, input int exp_ec);
      check({tag, "_busy_cycles"}, bc, 256);
      check({tag, "_done_seen"}, dc, 1);
      check({tag, "_seed_err"}, ec, exp_ec);
      check({tag, "_valid"}, valid0, 1'b1);
      @(negedge clk);
      check({tag, "_done_pulse"}, done0, 1'b0);
      check({tag, "_valid_hold"}, valid0, 1'b1);
   endtask

   initial begin
      int bc, dc, ec;
      logic [127:0] kv;
      logic [7:0] zs;
      rst_an = 1'b0;
      start0 = 0; seed0 = 0; rd_addr0 = 0; kidx0 = 0;
      start1 = 0; seed1 = 0; rd_addr1 = 0; kidx1 = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy0, 1'b0);
      check("rst_valid", valid0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_serr", serr0, 1'b0);
      check("rst_rd", rd_data0, 8'h00);
      check("rst_key", key0, 128'h0);
      check("rst_busy_small", busy1, 1'b0);
      rst_an = 1'b1;
      @(negedge clk);

      rd(1'b0, 8'd0, 4'd0, 8'h00, 128'h0, "pre_rd0");
      rd(1'b0, 8'd200, 4'd5, 8'h00, 128'h0, "pre_rd200");

      run_gen(8'h1D, -1, -1, bc, dc, ec);
      check_run("run1d", bc, dc, ec, 0);
      build_model(8'h1D);
      kv = mkey(0);
      rd(1'b0, 8'd0, 4'd0, 8'h1D, {40'h1D0E070381, kv[87:0]}, "hand_e0");
      rd(1'b0, 8'd1, 4'd1, 8'h0E, mkey(1), "hand_e1");
      rd(1'b0, 8'd2, 4'd0, 8'h07, kv, "hand_e2");
      rd(1'b0, 8'd3, 4'd0, 8'h03, kv, "hand_e3");
      rd(1'b0, 8'd4, 4'd15, 8'h81, mkey(15), "hand_e4");
      kv = mkey(1);
      check("key1_msb_vs_e16", kv[127:120], model[16]);
      rd(1'b0, 8'd16, 4'd1, model[16], kv, "key1_e16");
      check_table("t1d");

      run_gen(8'h1D, 100, -1, bc, dc, ec);
      check_run("restart_ign", bc, dc, ec, 0);
      check_table("t1d_ign");

      run_gen(8'hA5, -1, -1, bc, dc, ec);
      check_run("runa5", bc, dc, ec, 0);
      build_model(8'hA5);
      rd(1'b0, 8'd0, 4'd0, 8'hA5, mkey(0), "a5_e0");
      check_table("ta5");

      rd_addr0 = 8'd0; kidx0 = 4'd0;
      @(negedge clk);
      rst_an = 1'b0;
      #1;
      check("rst_done_rd", rd_data0, 8'h00);
      check("rst_done_key", key0, 128'h0);
      check("rst_done_valid", valid0, 1'b0);
      @(negedge clk);
      rst_an = 1'b1;
      @(negedge clk);

      run_gen(8'h1D, -1, 50, bc, dc, ec);
      run_gen(8'h3C, -1, -1, bc, dc, ec);
      check_run("run3c", bc, dc, ec, 0);
      build_model(8'h3C);
      check_table("t3c");

      run_gen(8'h00, -1, -1, bc, dc, ec);
      check_run("zero", bc, dc, ec, 1);
`ifdef LFSR_SEED_FIX_EN
      zs = 8'h1D;
      build_model(zs);
      rd(1'b0, 8'd0, 4'd0, 8'h1D, mkey(0), "zero_e0");
      rd(1'b0, 8'd1, 4'd0, 8'h0E, mkey(0), "zero_e1");
`else
      zs = 8'h00;
      build_model(zs);
      rd(1'b0, 8'd0, 4'd0, 8'h00, 128'h0, "zero_e0");
      rd(1'b0, 8'd1, 4'd0, 8'h00, 128'h0, "zero_e1");
`endif
      check_table("tzero");

      rd(1'b1, 8'd0, 4'd0, 8'h00, 128'h0, "small_pre");
      seed1 = 4'h9;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      bc = 0; dc = 0;
      for (int c = 0; c < 200; c++) begin
         if (busy1) bc++;
         if (done1) begin dc++; break; end
         @(negedge clk);
      end
      check("small_busy_cycles", bc, 64);
      check("small_done_seen", dc, 1);
      check("small_valid", valid1, 1'b1);
      @(negedge clk);
      rd(1'b1, 8'd0, 4'd0, 8'h09, 128'h9421, "small_e0");
      rd(1'b1, 8'd1, 4'd1, 8'h04, 128'h8CEF, "small_e1");
      rd(1'b1, 8'd2, 4'd0, 8'h02, 128'h9421, "small_e2");
      rd(1'b1, 8'd3, 4'd1, 8'h01, 128'h8CEF, "small_e3");
      rd(1'b1, 8'd4, 4'd0, 8'h08, 128'h9421, "small_e4");
      rd(1'b1, 8'd7, 4'd1, 8'h0F, 128'h8CEF, "small_e7");

      repeat (2) @(negedge clk);
      check("sb_drain", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lfsr_table_keygen.md
Name: lfsr_table_keygen

Overview:
- Parametrised successor to the team's LFSR S-box/key generator.
- Fills an internal table of DEPTH entries, W bits each, from a Fibonacci LFSR, one entry per clock, after a start handshake. The seed is set at run time and the taps by parameter.
- Exposes a registered random-access table read port and a registered round-key read port. Each key is KEY_W/W consecutive table entries, with the first entry in the MSBs.
- Feeds the AES datapath's S-box and round-key stages.

Parameters:
- W, 8, LFSR and table entry width in bits (W >= 2).
- DEPTH, 256, number of table entries (power of 2, >= KEY_W/W).
- TAPS, 8'h1D, feedback mask: fb = XOR of state bits s[i] where TAPS[i]=1.
- SEED, 8'h1D, default seed used by the optional zero-seed fix.
- KEY_W, 128, key width (multiple of W).
- Derived: EPK = KEY_W/W; NUM_KEYS = DEPTH/EPK; AW = clog2(DEPTH); KW = clog2(NUM_KEYS) (min 1).

Ports:
- clk, in, 1, clock; all state is updated on the rising edge.
- rst_an, in, 1, reset; asynchronous, active-low.
- start, in, 1, request generation; sampled only in IDLE or DONE.
- seed_i, in, W, seed captured on an accepted start.
- busy, out, 1, high while in GEN.
- valid, out, 1, table complete; high in DONE.
- done_p, out, 1, one-cycle pulse on the GEN->DONE transition.
- seed_err, out, 1, one-cycle pulse when an accepted start carries seed_i == 0.
- rd_addr, in, AW, table read address.
- rd_data, out, W, registered table entry.
- key_idx, in, KW, key select.
- key_o, out, KEY_W, registered key.

Behaviour:
- Reset (async, any time, including mid-GEN):
  - FSM goes to IDLE; busy, valid, done_p, seed_err, rd_data and key_o are 0; count is 0.
  - Table contents become don't-care. They are never visible, because reads return 0 while valid=0.
- FSM: IDLE, GEN, DONE.
  - IDLE/DONE + start=1: state<=seed_i, cnt<=0, valid<=0, go to GEN. seed_err pulses the next cycle if seed_i==0.
  - GEN, each cycle: mem[cnt]<=state; state<=next(state); cnt<=cnt+1.
  - When cnt==DEPTH-1 is written: go to DONE, valid<=1, done_p<=1 for one cycle.
  - start is ignored while in GEN; no restart and no queueing.
- LFSR: next(s) = {fb, s[W-1:1]} (right shift, feedback into the MSB), fb = ^(s & TAPS). Entry 0 is the seed itself.
- Latency: the start-accept edge is cycle 0; entries are written on cycles 1..DEPTH; valid rises at the end of cycle DEPTH.
- Zero seed: the LFSR locks at 0 and the table fills with zeros, and seed_err flags it. Without the optional feature the lock-up is not corrected.
- Read port: rd_data is registered 1 cycle after rd_addr and equals mem[rd_addr] when valid=1, else 0. rd_addr is full-range, so there is no out-of-range case.
- Key port: key_o is registered 1 cycle after key_idx and equals {mem[k*EPK], mem[k*EPK+1], ..., mem[k*EPK+EPK-1]} with k = key_idx, when valid=1, else 0.
  - If key_idx >= NUM_KEYS (non-power-of-2 NUM_KEYS), key_o is 0.
- Restart from DONE: valid drops the cycle after start is accepted, so reads return 0 until the new table is complete.
- start and reset deassertion in the same cycle: start is accepted at the first edge after rst_an goes high.

Optional Feature:
- Macro: LFSR_SEED_FIX_EN.
- Defined: on an accepted start with seed_i==0, the LFSR loads SEED instead of seed_i. seed_err still pulses, and the table is the SEED sequence.
- Undefined: seed_i is loaded verbatim; a zero seed produces an all-zero table with seed_err pulsed.

Test Plan:
- Reset then start with seed_i=8'h1D, defaults -> busy for 256 cycles, then done_p for one cycle and valid=1. rd_addr 0..4 -> rd_data 1D, 0E, 07, 03, 81, each one cycle after its address.
- After the case above, key_idx=0 -> key_o[127:88] = 40'h1D0E070381. key_o of key_idx=1 MSB byte equals rd_data at addr 16.
- Pulse start again at GEN cycle 100 -> ignored: done_p still at cycle 256 and the table is unchanged versus a clean run. Then start from DONE with seed_i=8'hA5 -> valid=0 the next cycle, and entry 0 = A5 after completion.
- Assert rst_an=0 at GEN cycle 50 -> busy, valid, rd_data and key_o go 0 immediately. A later start regenerates the full table correctly.
- start with seed_i=0 -> seed_err pulses.
  - Without the macro: all entries read 0.
  - With LFSR_SEED_FIX_EN: entry 0 = 1D and entry 1 = 0E.
- Reads while valid=0 (before first start and during GEN) -> rd_data=0 and key_o=0. Non-default W=4, DEPTH=64, TAPS=4'h9, KEY_W=16 -> 4 entries per key, and busy lasts 64 cycles.
